// File: rtl/tp_spi_seq.sv
// Touch-panel SPI sequencer: on pen-down, reads X then Y 12-bit conversions over a
// 24-period serial frame each and publishes the pair if the pen is still down.
module tp_spi_seq #(
    parameter int CLK_DIV    = 25,
    parameter int GAP_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pen_irq_n,
    input  logic        dout,
    output logic        dclk,
    output logic        din,
    output logic        cs_n,
    output logic [11:0] xaxis,
    output logic [11:0] yaxis,
    output logic        sample_valid,
    output logic        touching
);

    localparam logic [7:0] CMD_X = 8'hD0;
    localparam logic [7:0] CMD_Y = 8'h90;
    localparam int         DIV_W = 8;
    localparam int         GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'(GAP_CYCLES - 1);
    localparam logic [4:0]       LAST_PERIOD = 5'd24;

    typedef enum logic [2:0] {
        IDLE,
        XFER_X,
        XFER_Y,
        PUBLISH,
        GAP
    } state_t;

    state_t           state, next_state;
    logic [1:0]       pen_sync;
    logic             pen_down;
    logic [DIV_W-1:0] div_cnt;
    logic [4:0]       period;
    logic [GAP_W-1:0] gap_cnt;
    logic [11:0]      shift;
    logic [11:0]      x_hold;
    logic             in_xfer, next_xfer, frame_start;
    logic             phase_end, frame_end, gap_end;
    logic [7:0]       cur_cmd;
    logic             cmd_bit;

    // NOTE: the synchroniser resets to 1 so a reset never looks like a pen-down.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pen_sync <= 2'b11;
        else        pen_sync <= {pen_sync[0], pen_irq_n};
    end

    assign pen_down  = ~pen_sync[1];
    assign in_xfer   = (state == XFER_X) || (state == XFER_Y);
    assign phase_end = in_xfer && (div_cnt == DIV_LAST);
    assign frame_end = phase_end && dclk && (period == LAST_PERIOD);
    assign gap_end   = (state == GAP) && (gap_cnt == GAP_LAST);
    assign touching  = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pen_down)  next_state = XFER_X;
            XFER_X:  if (frame_end) next_state = XFER_Y;
            XFER_Y:  if (frame_end) next_state = PUBLISH;
            PUBLISH: next_state = GAP;
            GAP:     if (gap_end)   next_state = pen_down ? XFER_X : IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign next_xfer   = (next_state == XFER_X) || (next_state == XFER_Y);
    assign frame_start = next_xfer && (next_state != state);
    assign cur_cmd     = (state == XFER_Y) ? CMD_Y : CMD_X;
    // Bit for the period about to start: command bits on periods 1-8, zero after.
    assign cmd_bit     = (period < 5'd8) ? cur_cmd[3'd7 - period[2:0]] : 1'b0;

    // NOTE: all registered state below uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_n         <= 1'b1;
            dclk         <= 1'b0;
            din          <= 1'b0;
            div_cnt      <= '0;
            period       <= '0;
            gap_cnt      <= '0;
            shift        <= '0;
            x_hold       <= '0;
            xaxis        <= '0;
            yaxis        <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            cs_n         <= ~next_xfer;

            if (frame_start) begin
                div_cnt <= '0;
                period  <= 5'd1;
                dclk    <= 1'b0;
                din     <= (next_state == XFER_Y) ? CMD_Y[7] : CMD_X[7];
            end else if (in_xfer) begin
                if (phase_end) begin
                    div_cnt <= '0;
                    if (!dclk) begin
                        dclk <= 1'b1;
                        if (period >= 5'd10 && period <= 5'd21)
                            shift <= {shift[10:0], dout};
                    end else begin
                        dclk   <= 1'b0;
                        period <= period + 5'd1;
                        din    <= cmd_bit;
                    end
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
            end else begin
                div_cnt <= '0;
                period  <= '0;
                dclk    <= 1'b0;
                din     <= 1'b0;
            end

            if (state == XFER_X && frame_end)
                x_hold <= shift;

            // Y result is still in the shift register during PUBLISH.
            if (state == PUBLISH && pen_down) begin
                xaxis        <= x_hold;
                yaxis        <= shift;
                sample_valid <= 1'b1;
            end

            if (state == GAP) gap_cnt <= gap_cnt + GAP_W'(1);
            else              gap_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_tp_spi_seq.sv
// Directed bench for tp_spi_seq with a behavioural touch-controller model that
// decodes the command byte and returns the X or Y value on dout.
`timescale 1ns/1ps
module tb_tp_spi_seq;

    localparam int CLK_DIV    = 2;
    localparam int GAP_CYCLES = 20;
    localparam int PAIR_CLKS  = 2 * 24 * 2 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        pen_irq_n = 1'b1;
    logic        dout = 1'b0;
    logic        dclk, din, cs_n, sample_valid, touching;
    logic [11:0] xaxis, yaxis;

    int n_cmp  = 0;
    int n_fail = 0;

    tp_spi_seq #(.CLK_DIV(CLK_DIV), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pen_irq_n    (pen_irq_n),
        .dout         (dout),
        .dclk         (dclk),
        .din          (din),
        .cs_n         (cs_n),
        .xaxis        (xaxis),
        .yaxis        (yaxis),
        .sample_valid (sample_valid),
        .touching     (touching)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] x_val;
        logic [11:0] y_val;
        bit          release_mid;
        logic [11:0] exp_x;
        logic [11:0] exp_y;
        int          exp_pulses;
    } vec_t;

    // Controller model: period index counts dclk rises within a frame.
    logic [11:0] x_model = '0;
    logic [11:0] y_model = '0;
    logic [11:0] cur_val = '0;
    logic [7:0]  cmd_sh  = '0;
    logic [7:0]  cmd_log[$];
    int          rise_idx   = 0;
    int          rise_total = 0;
    int          din_err    = 0;

    always @(posedge dclk or posedge cs_n) begin
        if (cs_n) begin
            rise_idx = 0;
        end else begin
            rise_idx = (rise_idx == 24) ? 1 : rise_idx + 1;
            rise_total++;
            if (rise_idx <= 8) cmd_sh = {cmd_sh[6:0], din};
            else if (din !== 1'b0) din_err++;
            if (rise_idx == 8) begin
                cmd_log.push_back(cmd_sh);
                cur_val = (cmd_sh[6:4] == 3'b101) ? x_model : y_model;
            end
        end
    end

    always @(negedge dclk or posedge cs_n) begin
        if (cs_n) dout = 1'b0;
        else if (rise_idx >= 9 && rise_idx <= 20) dout = cur_val[20 - rise_idx];
        else dout = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_pair(input vec_t v, input string tag);
        int cyc, low_cnt, setup, pulses, hi, r0, c0;
        x_model = v.x_val;
        y_model = v.y_val;
        r0 = rise_total;
        c0 = cmd_log.size();
        pen_irq_n = 1'b0;
        cyc = 0;
        while (cs_n === 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
        check({tag, " cs_n falls"}, 32'(cs_n), 32'd0);
        low_cnt = 0;
        setup = -1;
        while (cs_n === 1'b0 && low_cnt < 400) begin
            if (setup < 0 && dclk === 1'b1) setup = low_cnt;
            if (v.release_mid && (rise_total - r0) == 11 && dclk === 1'b0) pen_irq_n = 1'b1;
            @(negedge clk);
            low_cnt++;
        end
        check({tag, " cs_n low clks"}, 32'(low_cnt), 32'(PAIR_CLKS));
        check({tag, " cs_n setup"}, 32'(setup), 32'(CLK_DIV));
        check({tag, " dclk periods"}, 32'(rise_total - r0), 32'd48);
        if (cmd_log.size() >= c0 + 2) begin
            check({tag, " cmd X"}, 32'(cmd_log[c0]), 32'hD0);
            check({tag, " cmd Y"}, 32'(cmd_log[c0 + 1]), 32'h90);
        end else begin
            check({tag, " cmd count"}, 32'(cmd_log.size() - c0), 32'd2);
        end
        pulses = 0;
        hi = 0;
        while (touching === 1'b1 && hi < GAP_CYCLES + 20) begin
            if (sample_valid === 1'b1) pulses++;
            if (cs_n !== 1'b1) check({tag, " cs_n high in gap"}, 32'(cs_n), 32'd1);
            if (hi == 3) pen_irq_n = 1'b1;
            @(negedge clk);
            hi++;
        end
        check({tag, " valid pulses"}, 32'(pulses), 32'(v.exp_pulses));
        check({tag, " publish+gap clks"}, 32'(hi), 32'(1 + GAP_CYCLES));
        check({tag, " xaxis"}, 32'(xaxis), 32'(v.exp_x));
        check({tag, " yaxis"}, 32'(yaxis), 32'(v.exp_y));
        check({tag, " idle cs_n"}, 32'(cs_n), 32'd1);
    endtask

    vec_t vecs[4];
    vec_t after_rst;
    logic [11:0] mx[3];
    logic [11:0] my[3];

    initial begin
        int cyc, hi, pulses, falls;
        logic prev_cs;

        vecs[0] = '{12'hA5C, 12'h3F1, 1'b0, 12'hA5C, 12'h3F1, 1};
        vecs[1] = '{12'h123, 12'hFED, 1'b1, 12'hA5C, 12'h3F1, 0};
        vecs[2] = '{12'h800, 12'h001, 1'b0, 12'h800, 12'h001, 1};
        vecs[3] = '{12'hFFF, 12'h000, 1'b0, 12'hFFF, 12'h000, 1};
        after_rst = '{12'h7E1, 12'h18F, 1'b0, 12'h7E1, 12'h18F, 1};
        mx = '{12'h111, 12'h222, 12'h333};
        my = '{12'hAAA, 12'hBBB, 12'hCCC};

        // Reset values
        #1 rst_n = 1'b0;
        #3;
        check("rst cs_n", 32'(cs_n), 32'd1);
        check("rst dclk", 32'(dclk), 32'd0);
        check("rst din", 32'(din), 32'd0);
        check("rst xaxis", 32'(xaxis), 32'd0);
        check("rst yaxis", 32'(yaxis), 32'd0);
        check("rst valid", 32'(sample_valid), 32'd0);
        check("rst touching", 32'(touching), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("idle touching", 32'(touching), 32'd0);

        // Single pairs: normal, release mid X frame, boundary values
        foreach (vecs[i]) run_pair(vecs[i], $sformatf("vec%0d", i));

        // Pen held for three pairs with changing values
        x_model = mx[0];
        y_model = my[0];
        pen_irq_n = 1'b0;
        cyc = 0;
        while (cs_n === 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
        for (int p = 0; p < 3; p++) begin
            cyc = 0;
            while (cs_n === 1'b0 && cyc < 400) begin @(negedge clk); cyc++; end
            hi = 0;
            pulses = 0;
            while (cs_n === 1'b1 && touching === 1'b1 && hi < 100) begin
                if (sample_valid === 1'b1) begin
                    pulses++;
                    check($sformatf("held%0d xaxis", p), 32'(xaxis), 32'(mx[p]));
                    check($sformatf("held%0d yaxis", p), 32'(yaxis), 32'(my[p]));
                    if (p < 2) begin
                        x_model = mx[p + 1];
                        y_model = my[p + 1];
                    end else begin
                        pen_irq_n = 1'b1;
                    end
                end
                @(negedge clk);
                hi++;
            end
            check($sformatf("held%0d pulses", p), 32'(pulses), 32'd1);
            check($sformatf("held%0d cs_n high clks", p), 32'(hi), 32'(1 + GAP_CYCLES));
        end
        check("held end touching", 32'(touching), 32'd0);

        // One-clk glitch on pen_irq_n while idle
        @(negedge clk);
        pen_irq_n = 1'b0;
        @(negedge clk);
        pen_irq_n = 1'b1;
        falls = 0;
        pulses = 0;
        prev_cs = cs_n;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (prev_cs === 1'b1 && cs_n === 1'b0) falls++;
            prev_cs = cs_n;
            if (sample_valid === 1'b1) pulses++;
        end
        check("glitch at most one pair", 32'(falls <= 1), 32'd1);
        check("glitch no valid", 32'(pulses), 32'd0);
        check("glitch idle", 32'(touching), 32'd0);
        check("glitch xaxis kept", 32'(xaxis), 32'h333);

        // Reset during Y frame period 15
        x_model = 12'h5A5;
        y_model = 12'hC3C;
        pen_irq_n = 1'b0;
        begin
            int r0;
            cyc = 0;
            while (cs_n === 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
            r0 = rise_total;
            cyc = 0;
            while ((rise_total - r0) < 38 && cyc < 400) begin @(negedge clk); cyc++; end
            check("reach Y period 14", 32'(rise_total - r0), 32'd38);
        end
        repeat (3) @(negedge clk);
        check("pre-rst cs_n low", 32'(cs_n), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("mid rst cs_n", 32'(cs_n), 32'd1);
        check("mid rst dclk", 32'(dclk), 32'd0);
        check("mid rst xaxis", 32'(xaxis), 32'd0);
        check("mid rst yaxis", 32'(yaxis), 32'd0);
        check("mid rst touching", 32'(touching), 32'd0);
        pen_irq_n = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (touching !== 1'b0 || cs_n !== 1'b1) hi++;
        end
        check("post rst stays idle", 32'(hi), 32'd0);
        run_pair(after_rst, "post_rst");

        check("din zero periods 9-24", 32'(din_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
